// File: rtl/dmem_mmio_responder.sv
// MEM-stage data responder: word-addressed data RAM plus an MMIO window holding a
// cycle counter, FIFO status, a host-drained TX mailbox FIFO, control and a halt flag.
module dmem_mmio_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        host_valid,
    output logic [31:0] host_data,
    input  logic        host_ready,
    output logic        halt
);

    localparam int unsigned RamDepth  = 2 ** RAM_AW;
    localparam int unsigned FifoDepth = 2 ** FIFO_AW;

    localparam logic [31:0] AddrCycle  = 32'hFFFF_0000;
    localparam logic [31:0] AddrStatus = 32'hFFFF_0004;
    localparam logic [31:0] AddrTxData = 32'hFFFF_0008;
    localparam logic [31:0] AddrCtrl   = 32'hFFFF_000C;
    localparam logic [31:0] AddrHalt   = 32'hFFFF_0010;

    logic [31:0] ram_mem  [RamDepth];
    logic [31:0] fifo_mem [FifoDepth];

    logic [31:0]        cycle_q, cycle_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               halt_q, halt_d;

    logic [31:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram, sel_cycle, sel_status, sel_tx, sel_ctrl, sel_halt;
    logic              empty, full, pop, push_req, push, flush;
    logic              unused_addr_bits;

    // Byte offset is ignored: all accesses are whole words.
    assign word_addr        = {addr[31:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];
    assign ram_idx          = addr[RAM_AW+1:2];

    assign sel_ram    = (addr[31:28] == 4'h0);
    assign sel_cycle  = (word_addr == AddrCycle);
    assign sel_status = (word_addr == AddrStatus);
    assign sel_tx     = (word_addr == AddrTxData);
    assign sel_ctrl   = (word_addr == AddrCtrl);
    assign sel_halt   = (word_addr == AddrHalt);

    assign empty    = (count_q == '0);
    assign full     = (count_q == (FIFO_AW + 1)'(FifoDepth));
    assign pop      = host_valid & host_ready;
    assign push_req = memwrite & sel_tx;
    // A same-cycle pop frees the slot the push needs.
    assign push     = push_req & (~full | pop);
    assign flush    = memwrite & sel_ctrl & write_data[1];

    assign host_valid = ~empty;
    assign host_data  = empty ? 32'd0 : fifo_mem[rd_ptr_q];
    assign halt       = halt_q;

    always_comb begin
        cycle_d = cycle_q;
        if (memwrite && sel_cycle) begin
            cycle_d = write_data;
        end else if (!halt_q) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (memwrite && sel_ctrl && write_data[0]) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (FIFO_AW + 1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (FIFO_AW + 1)'(1);
            end
        end
    end

    assign halt_d = (memwrite && sel_halt) ? write_data[0] : halt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            halt_q   <= halt_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (memwrite && sel_ram) begin
            ram_mem[ram_idx] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr_q] <= write_data;
        end
    end

    always_comb begin
        read_data = 32'd0;
        if (memread) begin
            if (sel_ram) begin
                read_data = ram_mem[ram_idx];
            end else if (sel_cycle) begin
                read_data = cycle_q;
            end else if (sel_status) begin
                read_data = {16'd0, {(7 - FIFO_AW){1'b0}}, count_q, 5'd0, ovf_q, full, empty};
            end else if (sel_halt) begin
                read_data = {31'd0, halt_q};
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed plus randomized bench for dmem_mmio_responder, checked against a
// transaction-level model (associative RAM, queue FIFO, integer counter).
module tb_dmem_mmio_responder;

    localparam logic [31:0] ACycle  = 32'hFFFF_0000;
    localparam logic [31:0] AStatus = 32'hFFFF_0004;
    localparam logic [31:0] ATx     = 32'hFFFF_0008;
    localparam logic [31:0] ACtrl   = 32'hFFFF_000C;
    localparam logic [31:0] AHalt   = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        memwrite, memread;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        halt;

    dmem_mmio_responder #(
        .RAM_AW (10),
        .FIFO_AW(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .memwrite  (memwrite),
        .memread   (memread),
        .write_data(write_data),
        .read_data (read_data),
        .host_valid(host_valid),
        .host_data (host_data),
        .host_ready(host_ready),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    string step = "init";

    logic [31:0] ram_m [int];
    logic [31:0] q_m   [$];
    logic [31:0] cyc_m;
    bit          halt_m, ovf_m;
    logic [31:0] last_rd, last_hd, frozen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", step, tag, got, exp);
        end
    endtask

    // 0 ram, 1 cycle, 2 status, 3 tx, 4 ctrl, 5 halt, 6 unmapped
    function automatic int dec(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if ((a >> 28) == 0) return 0;
        if (w == ACycle)    return 1;
        if (w == AStatus)   return 2;
        if (w == ATx)       return 3;
        if (w == ACtrl)     return 4;
        if (w == AHalt)     return 5;
        return 6;
    endfunction

    task automatic model_reset();
        cyc_m  = 0;
        halt_m = 0;
        ovf_m  = 0;
        q_m.delete();
        ram_m.delete();
    endtask

    task automatic op(input bit wr, input bit rd, input logic [31:0] a,
                      input logic [31:0] wd, input bit hr);
        int          kind, idx, n;
        bit          ok, pop, flush;
        logic [31:0] exp_rd;
        memwrite   = wr;
        memread    = rd;
        addr       = a;
        write_data = wd;
        host_ready = hr;
        #2;
        kind   = dec(a);
        idx    = int'((a >> 2) % 1024);
        n      = q_m.size();
        ok     = 1;
        exp_rd = 0;
        if (rd) begin
            case (kind)
                0: if (ram_m.exists(idx)) exp_rd = ram_m[idx]; else ok = 0;
                1: exp_rd = cyc_m;
                2: exp_rd = 32'(n * 256 + (ovf_m ? 4 : 0) + (n == 8 ? 2 : 0) + (n == 0 ? 1 : 0));
                5: exp_rd = {31'd0, halt_m};
                default: exp_rd = 0;
            endcase
        end
        last_rd = read_data;
        last_hd = host_data;
        if (ok) chk("read_data", read_data, exp_rd);
        chk("host_valid", {31'd0, host_valid}, (n != 0) ? 32'd1 : 32'd0);
        chk("host_data", host_data, (n != 0) ? q_m[0] : 32'd0);
        chk("halt", {31'd0, halt}, {31'd0, halt_m});
        @(posedge clk);
        pop   = (n != 0) && hr;
        flush = wr && kind == 4 && wd[1];
        if (!(wr && kind == 1) && !halt_m) cyc_m = cyc_m + 1;
        if (wr) begin
            case (kind)
                0: ram_m[idx] = wd;
                1: cyc_m = wd;
                4: if (wd[0]) ovf_m = 0;
                5: halt_m = wd[0];
                default: ;
            endcase
        end
        if (flush) begin
            q_m.delete();
        end else begin
            if (pop) void'(q_m.pop_front());
            if (wr && kind == 3) begin
                if (q_m.size() < 8) q_m.push_back(wd);
                else ovf_m = 1;
            end
        end
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        addr       = 0;
        memwrite   = 0;
        memread    = 0;
        write_data = 0;
        host_ready = 0;
        model_reset();
        #11;
        step = "reset";
        chk("halt", {31'd0, halt}, 0);
        chk("host_valid", {31'd0, host_valid}, 0);
        chk("host_data", host_data, 0);
        chk("read_data", read_data, 0);
        reset = 1'b1;

        step = "ram";
        op(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        op(0, 1, 32'h0000_0010, 0, 0);
        chk("load", last_rd, 32'hDEAD_BEEF);
        op(0, 1, 32'h0000_1010, 0, 0);
        chk("alias", last_rd, 32'hDEAD_BEEF);

        step = "cycle";
        repeat (97) op(0, 0, 0, 0, 0);
        op(0, 1, ACycle, 0, 0);
        chk("cyc100", (last_rd >= 99 && last_rd <= 101) ? 32'd1 : 32'd0, 1);
        repeat (18) op(0, 0, 0, 0, 0);
        op(1, 0, AHalt, 1, 0);
        op(0, 1, ACycle, 0, 0);
        frozen = last_rd;
        repeat (50) op(0, 0, 0, 0, 0);
        op(0, 1, ACycle, 0, 0);
        chk("frozen", last_rd, frozen);
        op(1, 0, AHalt, 0, 0);
        op(1, 0, ACycle, 32'hFFFF_FFFF, 0);
        op(0, 1, ACycle, 0, 0);
        chk("wrap_pre", last_rd, 32'hFFFF_FFFF);
        op(0, 1, ACycle, 0, 0);
        chk("wrap", last_rd, 0);

        step = "fifo";
        for (int i = 1; i <= 8; i++) op(1, 0, ATx, 32'(i), 0);
        op(0, 1, AStatus, 0, 0);
        chk("status_full", last_rd, 32'h0000_0802);
        op(1, 0, ATx, 9, 0);
        op(0, 1, AStatus, 0, 0);
        chk("status_ovf", last_rd, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) begin
            op(0, 0, 0, 0, 1);
            chk("drain", last_hd, 32'(i));
        end
        op(0, 1, AStatus, 0, 1);
        chk("status_empty", last_rd, 32'h0000_0005);

        step = "pushpop";
        op(1, 0, ACtrl, 1, 0);
        for (int i = 1; i <= 8; i++) op(1, 0, ATx, 32'(100 + i), 0);
        op(1, 0, ATx, 32'd999, 1);
        op(0, 1, AStatus, 0, 0);
        chk("status", last_rd, 32'h0000_0802);
        for (int i = 0; i < 8; i++) op(0, 0, 0, 0, 1);
        chk("last_out", last_hd, 32'd999);

        step = "ctrl";
        for (int i = 1; i <= 9; i++) op(1, 0, ATx, 32'(200 + i), 0);
        repeat (5) op(0, 0, 0, 0, 1);
        op(0, 1, AStatus, 0, 0);
        chk("pre", last_rd, 32'h0000_0304);
        op(1, 0, ACtrl, 3, 0);
        op(0, 1, AStatus, 0, 0);
        chk("post", last_rd, 32'h0000_0001);

        step = "async_reset";
        op(1, 0, AHalt, 1, 0);
        for (int i = 1; i <= 4; i++) op(1, 0, ATx, 32'(300 + i), 0);
        op(0, 0, 0, 0, 1);
        memwrite = 0;
        memread  = 0;
        #2 reset = 1'b0;
        #1;
        chk("halt", {31'd0, halt}, 0);
        chk("host_valid", {31'd0, host_valid}, 0);
        chk("host_data", host_data, 0);
        chk("read_data", read_data, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        op(0, 1, ACycle, 0, 1);
        chk("cycle0", last_rd, 0);

        step = "random";
        for (int t = 0; t < 600; t++) begin
            int          k;
            logic [31:0] a, wd;
            k  = int'($urandom_range(0, 11));
            wd = $urandom;
            case (k)
                0, 1, 2, 3: a = ($urandom & 32'h0FFF_F000) | ($urandom_range(0, 15) << 2);
                4:          a = ACycle;
                5:          a = AStatus;
                6, 7, 8:    a = ATx;
                9:          begin a = ACtrl; wd = ($urandom_range(0, 3) == 0) ? wd : (wd & 32'hFFFF_FFFD); end
                10:         begin a = AHalt; wd = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0; end
                default: begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'hFFFF_0014;
                        1:       a = 32'h4000_0010;
                        default: a = 32'hFFFF_1000;
                    endcase
                end
            endcase
            if (k != 0 && k != 1 && k != 2 && k != 3) a = a | 32'($urandom_range(0, 3));
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd,
               $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Data-side responder for the pipelined MIPS core's MEM-stage port. It decodes the core's address, read strobe, write strobe and store data, and returns load data combinationally. It holds a word-addressed data RAM plus a small MMIO window: a cycle counter, a status register, a TX mailbox FIFO drained by an external host, and a halt flag used to bracket AES runs.

Parameters:
RAM_AW, 10, log2 of data RAM depth in 32-bit words (1024 words).
FIFO_AW, 3, log2 of TX FIFO depth (8 entries).

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (reset==0 resets)
addr  input  32  byte address from core EX/MEM register
memwrite  input  1  store strobe
memread  input  1  load strobe
write_data  input  32  store data
read_data  output  32  load data, combinational from addr/memread/state
host_valid  output  1  TX FIFO non-empty
host_data  output  32  TX FIFO head word
host_ready  input  1  host pops head when host_valid & host_ready
halt  output  1  sticky program-done flag

Behaviour:
- Address decode on addr[31:2]; addr[1:0] ignored (word access only, no byte enables).
- RAM region: addr[31:28]==4'h0; index = addr[RAM_AW+1:2]; higher bits inside region alias.
- MMIO region, exact word match: 0xFFFF0000 CYCLE, 0xFFFF0004 STATUS, 0xFFFF0008 TXDATA, 0xFFFF000C CTRL, 0xFFFF0010 HALT. All other addresses are unmapped.
- Read path is purely combinational (zero latency); the core captures read_data at the same posedge that retires the access.
  - memread==0 -> read_data=0.
  - RAM -> stored word. CYCLE -> counter.
  - STATUS -> {16'd0, 8'd count, 5'd0, overflow, full, empty}.
  - HALT -> {31'd0, halt}.
  - TXDATA, CTRL, unmapped -> 0.
- Writes commit at posedge when memwrite==1. A load on the following cycle observes the new value. memread and memwrite both 1: the write commits, and read_data shows pre-write contents.
- RAM has no reset; contents are undefined until written.
- CYCLE: 32-bit counter, +1 every clock while halt==0, wraps 0xFFFFFFFF->0. It freezes while halt==1. A write loads write_data and overrides that cycle's increment.
- TXDATA write pushes write_data. The push is accepted if count<2^FIFO_AW, or if a pop occurs in the same cycle. When full with no pop, the word is dropped and the sticky overflow flag is set.
- Pop: on host_valid & host_ready at posedge, the head advances. host_valid = !empty. host_data = head word, and is 0 when empty. A pop and a push in the same cycle leave count unchanged.
- Pointers wrap modulo 2^FIFO_AW. count ranges 0..2^FIFO_AW and is FIFO_AW+1 bits, zero-extended into STATUS.
- CTRL write: bit0=1 clears overflow; bit1=1 flushes the FIFO (pointers and count to 0). Flush takes priority over a same-cycle push or pop to the FIFO. Other bits are ignored.
- HALT write: bit0=1 sets halt; bit0=0 clears it.
- Unmapped writes are ignored, with no side effects.
- Reset (async, any time, including mid-transfer): CYCLE=0, FIFO empty, overflow=0, halt=0. Consequently host_valid=0, host_data=0, and read_data=0 unless memread is asserted.

Test Plan:
1. Reset, then store 0xDEADBEEF to 0x00000010, then load 0x00000010 on the next cycle -> read_data=0xDEADBEEF. A load at 0x00001010 (alias, RAM_AW=10) also returns 0xDEADBEEF.
2. Run 100 cycles after reset, load CYCLE -> 100±1 per the sampling cycle. Write HALT=1 at cycle 120, wait 50 cycles, load CYCLE -> value frozen. Write CYCLE=0xFFFFFFFF with halt=0 -> counter reads 0 one cycle later.
3. Push 8 words 1..8 with host_ready=0 -> STATUS=0x0000_0802 (count=8, full=1). A 9th push -> overflow=1, FIFO is unchanged. Then host_ready=1 -> host_data yields 1..8 in order, host_valid drops after the 8th pop, and STATUS=0x0000_0005.
4. With the FIFO full, push and pop in the same cycle -> push accepted, count stays 8, overflow not set, and the new word exits last.
5. Write CTRL=0x3 while the FIFO holds 3 words and overflow=1 -> the next cycle STATUS=0x0000_0001 and host_valid=0.
6. Assert reset=0 asynchronously mid-way through a FIFO drain and while halt=1 -> outputs clear immediately: halt=0, host_valid=0, CYCLE reads 0 after release.
